// File: rtl/button_gesture_pkg.sv
// Shared state encodings, counter-width helper and register macro for button_gesture.
// Encodings are fixed 3-bit values so the reset state (WAIT_RELEASE) is all-zero.
`define BUTTON_GESTURE_DFF(q, d, rstval) always_ff @(posedge i_clk or posedge i_rst) if (i_rst) q <= rstval; else if (i_cg) q <= d;

package button_gesture_pkg;

  localparam logic [2:0] ENC_WAIT_RELEASE = 3'd0;
  localparam logic [2:0] ENC_IDLE         = 3'd1;
  localparam logic [2:0] ENC_PRESSED1     = 3'd2;
  localparam logic [2:0] ENC_LONG_HELD    = 3'd3;
  localparam logic [2:0] ENC_WAIT_SECOND  = 3'd4;
  localparam logic [2:0] ENC_PRESSED2     = 3'd5;

  typedef enum logic [2:0] {
    ST_WAIT_RELEASE = ENC_WAIT_RELEASE,
    ST_IDLE         = ENC_IDLE,
    ST_PRESSED1     = ENC_PRESSED1,
    ST_LONG_HELD    = ENC_LONG_HELD,
    ST_WAIT_SECOND  = ENC_WAIT_SECOND,
    ST_PRESSED2     = ENC_PRESSED2
  } state_t;

  // Counter only has to reach the larger threshold minus one; gap is ignored without double-press.
  function automatic int cnt_width(input int long_cycles, input int gap_cycles, input bit double_en);
    int m;
    m = long_cycles;
    if (double_en && (gap_cycles > long_cycles)) m = gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_gesture.sv
// Classifies debounced button gestures into short / long / double pulses, all outputs registered.
// Double-press detection is built only when BUTTON_GESTURE_DOUBLE_EN is defined.
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int LONG_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_debounced,
  output logic o_shortPress,
  output logic o_longPress,
  output logic o_doublePress,
  output logic o_held,
  output logic o_busy
);

`ifdef BUTTON_GESTURE_DOUBLE_EN
  localparam bit DOUBLE_EN = 1'b1;
`else
  localparam bit DOUBLE_EN = 1'b0;
`endif

  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES, DOUBLE_EN);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BUTTON_GESTURE_DOUBLE_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

  if (LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_param_check
    $error("button_gesture: LONG_CYCLES and GAP_CYCLES must both be at least 2");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, double_nxt, held_nxt, busy_nxt;

  `BUTTON_GESTURE_DFF(state, state_nxt, ST_WAIT_RELEASE)
  `BUTTON_GESTURE_DFF(cnt, cnt_nxt, '0)
  `BUTTON_GESTURE_DFF(o_shortPress, short_nxt, 1'b0)
  `BUTTON_GESTURE_DFF(o_longPress, long_nxt, 1'b0)
  `BUTTON_GESTURE_DFF(o_doublePress, double_nxt, 1'b0)
  `BUTTON_GESTURE_DFF(o_held, held_nxt, 1'b0)
  `BUTTON_GESTURE_DFF(o_busy, busy_nxt, 1'b0)

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      ST_WAIT_RELEASE: begin
        if (!i_debounced) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_debounced) begin
          state_nxt = ST_PRESSED1;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PRESSED1: begin
        if (i_debounced) begin
          if (cnt == LONG_LAST) begin
            long_nxt  = 1'b1;
            state_nxt = ST_LONG_HELD;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
`ifdef BUTTON_GESTURE_DOUBLE_EN
          state_nxt = ST_WAIT_SECOND;
          cnt_nxt   = CNT_ONE;
`else
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_LONG_HELD: begin
        if (!i_debounced) state_nxt = ST_IDLE;
      end
`ifdef BUTTON_GESTURE_DOUBLE_EN
      ST_WAIT_SECOND: begin
        if (i_debounced) begin
          state_nxt = ST_PRESSED2;
        end else if (cnt == GAP_LAST) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_PRESSED2: begin
        if (!i_debounced) begin
          double_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_WAIT_RELEASE;
        cnt_nxt   = '0;
      end
    endcase
    // Level outputs are registered from the next state so they line up with the pulses.
    held_nxt = (state_nxt == ST_LONG_HELD);
    busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_RELEASE);
  end

endmodule

// File: tb/tb_button_gesture.sv
// Randomised and directed bench for button_gesture against a run-length reference model.
module tb_button_gesture;

  localparam int LONG = 16;
  localparam int GAP  = 8;
`ifdef BUTTON_GESTURE_DOUBLE_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_cg = 1'b1;
  logic i_debounced = 1'b1;
  logic o_shortPress, o_longPress, o_doublePress, o_held, o_busy;

  button_gesture #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_debounced(i_debounced),
    .o_shortPress(o_shortPress), .o_longPress(o_longPress), .o_doublePress(o_doublePress),
    .o_held(o_held), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: gesture described by run lengths (first press, gap, second press).
  bit armed, long_on;
  int hi1, lo, hi2;
  bit e_short, e_long, e_double, e_held, e_busy;

  task automatic model_reset();
    armed = 0; long_on = 0; hi1 = 0; lo = 0; hi2 = 0;
    e_short = 0; e_long = 0; e_double = 0; e_held = 0; e_busy = 0;
  endtask

  task automatic clear_gesture();
    hi1 = 0; lo = 0; hi2 = 0;
  endtask

  task automatic model_step(input bit d);
    e_short = 0; e_long = 0; e_double = 0;
    if (!armed) begin
      if (!d) armed = 1;
    end else if (long_on) begin
      if (!d) begin long_on = 0; clear_gesture(); end
    end else if (hi1 == 0) begin
      if (d) hi1 = 1;
    end else if (lo == 0) begin
      if (d) begin
        hi1++;
        if (hi1 == LONG) begin e_long = 1; long_on = 1; clear_gesture(); end
      end else if (DE) begin
        lo = 1;
      end else begin
        e_short = 1; clear_gesture();
      end
    end else if (hi2 == 0) begin
      if (d) hi2 = 1;
      else begin
        lo++;
        if (lo == GAP) begin e_short = 1; clear_gesture(); end
      end
    end else begin
      if (d) hi2++;
      else begin e_double = 1; clear_gesture(); end
    end
    e_held = long_on;
    e_busy = armed && (long_on || hi1 > 0);
  endtask

  int n_short, n_long, n_double, n_held, n_busy;

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_double = 0; n_held = 0; n_busy = 0;
  endtask

  task automatic compare_all();
    chk("short", o_shortPress, e_short);
    chk("long", o_longPress, e_long);
    chk("double", o_doublePress, e_double);
    chk("held", o_held, e_held);
    chk("busy", o_busy, e_busy);
    chk("one_pulse", ({31'b0, o_shortPress} + o_longPress + o_doublePress) <= 1, 1);
  endtask

  task automatic tick(input bit d, input bit cg);
    i_debounced = d;
    i_cg = cg;
    @(posedge i_clk);
    if (cg && !i_rst) model_step(d);
    #1;
    compare_all();
    n_short += o_shortPress; n_long += o_longPress; n_double += o_doublePress;
    n_held += o_held; n_busy += o_busy;
  endtask

  task automatic run(input bit d, input int n);
    for (int k = 0; k < n; k++) tick(d, 1'b1);
  endtask

  task automatic pulse_reset(input bit d, input int n);
    i_rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    for (int k = 0; k < n; k++) tick(d, 1'b1);
    i_rst = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    model_reset();
    clear_counts();

    // Button held through reset and well after: never a gesture.
    repeat (3) @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;
    run(1, 30);
    run(0, 20);
    chk("hold_thru_reset_pulses", n_short + n_long + n_double, 0);
    chk("hold_thru_reset_busy", n_busy, 0);

    clear_counts();
    run(1, LONG - 1);
    run(0, GAP);
    chk("short_15_count", n_short, 1);
    chk("short_15_held", n_held, 0);
    chk("short_15_long", n_long, 0);
    run(0, 4);

    clear_counts();
    run(1, LONG);
    chk("long_16_pulse", n_long, 1);
    run(1, 5);
    run(0, 1);
    run(0, 10);
    chk("long_held_cycles", n_held, 6);
    chk("long_no_short", n_short, 0);

    clear_counts();
    run(1, 5); run(0, 7); run(1, 3); run(0, 10);
    chk("double_count", n_double, DE ? 1 : 0);
    chk("double_short_count", n_short, DE ? 0 : 2);

    clear_counts();
    run(1, 5); run(0, GAP); run(1, LONG); run(0, 10);
    chk("gap8_short", n_short, 1);
    chk("gap8_new_long", n_long, 1);
    chk("gap8_double", n_double, 0);

    clear_counts();
    run(1, 10);
    pulse_reset(1, 2);
    run(1, 5);
    run(0, 10);
    chk("midreset_pulses", n_short + n_long + n_double, 0);

    // Five gated cycles inside the gap delay the short commit by five cycles.
    run(1, 4);
    lat = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick(0, !(k >= 3 && k < 8));
      lat++;
      if (o_shortPress) seen = 1;
    end
    chk("cg_short_seen", seen, 1);
    chk("cg_short_latency", lat, DE ? GAP + 5 : 1);
    run(0, 4);

    for (int g = 0; g < 400; g++) begin
      bit lvl;
      int len;
      lvl = g[0];
      len = lvl ? $urandom_range(1, LONG + 4) : $urandom_range(1, GAP + 4);
      if ($urandom_range(0, 49) == 0) pulse_reset($urandom_range(0, 1), $urandom_range(1, 3));
      for (int k = 0; k < len; k++) tick(lvl, $urandom_range(0, 9) != 0);
    end
    run(0, GAP + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
